adpll_hop_ctr: RTL and testbench

ADPLL_HOP_CTR -- requirements
Module: adpll_hop_ctr

---
 rtl/adpll_hop_ctr.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_adpll_hop_ctr.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_hop_ctr.sv
// ---------------------------------------------------------------------------
// adpll_hop_ctr
// Frequency-hop sequencer for an all-digital PLL. A CPU programs a table of
// FCW profiles, a hop count, a dwell length and a lock timeout. Once started,
// the sequencer steps through the profiles. For each profile it loads the FCW,
// waits for the core to report lock, dwells for the programmed time and then
// hops to the next profile.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active low
//   sel, write   CPU access strobe / write qualifier
//   address      CPU register address
//   data_in      CPU write data
//   data_out     CPU read data, valid while ready is high
//   ready        sel delayed by one clock
//   channel_lock lock indication from the ADPLL core
//   fcw          frequency control word driven to the core
//   adpll_en     core enable (high while waiting for lock or dwelling)
//   irq          level interrupt: irq_en & (done | timeout_err | lock_lost)
// ---------------------------------------------------------------------------
module adpll_hop_ctr #(
  parameter int FCWW   = 26,
  parameter int NPROF  = 8,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              ready,
  input  logic              channel_lock,
  output logic [FCWW-1:0]   fcw,
  output logic              adpll_en,
  output logic              irq
);

  localparam int IW = (NPROF > 1) ? $clog2(NPROF) : 1;
  localparam logic [FCWW-1:0]  FCW_RST     = FCWW'(32'h0262_0000);
  localparam logic [CNT_W-1:0] DWELL_RST   = CNT_W'(32'h0000_0100);
  localparam logic [CNT_W-1:0] TIMEOUT_RST = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_LOCK = 2'd2,
    S_DWELL     = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Configuration registers
  logic              loop_en;
  logic              irq_en;
  logic [5:0]        nhop;
  logic [CNT_W-1:0]  dwell;
  logic [CNT_W-1:0]  timeout;
  logic [FCWW-1:0]   prof [NPROF];

  // Sequencer datapath
  logic [IW-1:0]     idx;
  logic [CNT_W-1:0]  tcnt;
  logic [CNT_W-1:0]  dcnt;
  logic              done;
  logic              timeout_err;
  logic              lock_lost;
  logic              busy;

  // CPU decode
  logic [31:0]       addr32;
  logic              wr;
  logic              ctrl_wr;
  logic              status_wr;
  logic              start;
  logic              stop;
  logic              soft_rst;
  logic              prof_hit;
  logic [IW-1:0]     prof_idx;
  logic [31:0]       rdata;
  logic              unused_data;

  // Sequencer events produced by the next-state logic
  logic              start_go;
  logic              load_fcw;
  logic              lock_acq;
  logic              to_abort;
  logic              tcnt_inc;
  logic              lost;
  logic              hop;
  logic              dcnt_inc;

  logic [5:0]        hops_m1;
  logic              last_hop;

  assign addr32    = 32'(address);
  assign wr        = sel & write;
  assign ctrl_wr   = wr && (addr32 == 32'd0);
  assign status_wr = wr && (addr32 == 32'd1);
  assign start     = ctrl_wr & data_in[0];
  assign stop      = ctrl_wr & data_in[1];
  assign soft_rst  = ctrl_wr & data_in[4];
  assign prof_hit  = (addr32 >= 32'd16) && (addr32 < 32'(16 + NPROF));
  assign prof_idx  = IW'(addr32 - 32'd16);
  // Not every data_in bit lands in a register; fold them so none dangle.
  assign unused_data = ^data_in;

  // Effective hop count is NHOP clamped to [1, NPROF]; keep it as last index.
  always_comb begin
    if (nhop == 6'd0) begin
      hops_m1 = 6'd0;
    end else if (nhop > 6'(NPROF)) begin
      hops_m1 = 6'(NPROF - 1);
    end else begin
      hops_m1 = nhop - 6'd1;
    end
  end

  assign last_hop = (6'(idx) == hops_m1);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic and datapath events
  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    load_fcw  = 1'b0;
    lock_acq  = 1'b0;
    to_abort  = 1'b0;
    tcnt_inc  = 1'b0;
    lost      = 1'b0;
    hop       = 1'b0;
    dcnt_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_go  = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        load_fcw  = 1'b1;
        state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock has priority over an expiring timeout in the same cycle.
        if (channel_lock) begin
          lock_acq  = 1'b1;
          state_nxt = S_DWELL;
        end else if (tcnt == timeout) begin
          to_abort  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tcnt_inc  = 1'b1;
        end
      end
      S_DWELL: begin
        if (!channel_lock) begin
          lost      = 1'b1;
          state_nxt = S_WAIT_LOCK;
        end else if (dcnt == dwell) begin
          hop       = 1'b1;
          state_nxt = (last_hop && !loop_en) ? S_IDLE : S_LOAD;
        end else begin
          dcnt_inc  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // stop (or a soft reset) beats everything, including a same-write start,
    // and freezes fcw/idx/flags where they are.
    if (stop || soft_rst) begin
      state_nxt = S_IDLE;
      start_go  = 1'b0;
      load_fcw  = 1'b0;
      lock_acq  = 1'b0;
      to_abort  = 1'b0;
      tcnt_inc  = 1'b0;
      lost      = 1'b0;
      hop       = 1'b0;
      dcnt_inc  = 1'b0;
    end
  end

  // FSM outputs
  always_comb begin
    busy     = (state != S_IDLE);
    adpll_en = (state == S_WAIT_LOCK) || (state == S_DWELL);
  end

  // Configuration registers; table/count writes are ignored while hopping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loop_en <= 1'b0;
      irq_en  <= 1'b0;
      nhop    <= 6'd1;
      dwell   <= DWELL_RST;
      timeout <= TIMEOUT_RST;
      for (int i = 0; i < NPROF; i++) prof[i] <= FCW_RST;
    end else if (soft_rst) begin
      loop_en <= 1'b0;
      irq_en  <= 1'b0;
      nhop    <= 6'd1;
      dwell   <= DWELL_RST;
      timeout <= TIMEOUT_RST;
      for (int i = 0; i < NPROF; i++) prof[i] <= FCW_RST;
    end else begin
      if (ctrl_wr) begin
        loop_en <= data_in[2];
        irq_en  <= data_in[3];
      end
      if (wr && !busy) begin
        if (addr32 == 32'd2) nhop    <= data_in[5:0];
        if (addr32 == 32'd3) dwell   <= data_in[CNT_W-1:0];
        if (addr32 == 32'd4) timeout <= data_in[CNT_W-1:0];
        if (prof_hit)        prof[prof_idx] <= data_in[FCWW-1:0];
      end
    end
  end

  // Sequencer datapath, sticky flags and interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcw         <= FCW_RST;
      idx         <= '0;
      tcnt        <= '0;
      dcnt        <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      lock_lost   <= 1'b0;
      irq         <= 1'b0;
    end else if (soft_rst) begin
      fcw         <= FCW_RST;
      idx         <= '0;
      tcnt        <= '0;
      dcnt        <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      lock_lost   <= 1'b0;
      irq         <= 1'b0;
    end else begin
      // W1C first so that a flag raised in the same cycle is not lost.
      if (status_wr) begin
        if (data_in[1]) timeout_err <= 1'b0;
        if (data_in[2]) done        <= 1'b0;
        if (data_in[3]) lock_lost   <= 1'b0;
      end
      if (start_go) begin
        idx         <= '0;
        done        <= 1'b0;
        timeout_err <= 1'b0;
        lock_lost   <= 1'b0;
      end
      if (load_fcw) begin
        fcw  <= prof[idx];
        tcnt <= '0;
      end
      if (lock_acq) dcnt <= '0;
      if (tcnt_inc) tcnt <= tcnt + CNT_W'(1);
      if (to_abort) timeout_err <= 1'b1;
      if (lost) begin
        lock_lost <= 1'b1;
        tcnt      <= '0;
      end
      if (dcnt_inc) dcnt <= dcnt + CNT_W'(1);
      if (hop) begin
        if (!last_hop) begin
          idx <= idx + IW'(1);
        end else if (loop_en) begin
          idx <= '0;
        end else begin
          done <= 1'b1;
        end
      end
      irq <= irq_en & (done | timeout_err | lock_lost);
    end
  end

  // Read mux
  always_comb begin
    rdata = 32'hFFFF_FFFF;
    if (prof_hit) begin
      rdata = 32'(prof[prof_idx]);
    end else begin
      case (addr32)
        32'd0:   rdata = {27'b0, 1'b0, irq_en, loop_en, 2'b0};
        32'd1:   rdata = {19'b0, 5'(idx), 4'b0, lock_lost, done, timeout_err, busy};
        32'd2:   rdata = 32'(nhop);
        32'd3:   rdata = 32'(dwell);
        32'd4:   rdata = 32'(timeout);
        default: rdata = 32'hFFFF_FFFF;
      endcase
    end
  end

  // Read data is captured with sel and presented alongside ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready    <= 1'b0;
      data_out <= '0;
    end else begin
      ready <= sel;
      if (sel) data_out <= rdata;
    end
  end

endmodule

// File: tb/tb_adpll_hop_ctr.sv
module tb_adpll_hop_ctr;

  localparam int FCWW   = 26;
  localparam int NPROF  = 8;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              sel;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              ready;
  logic              channel_lock;
  logic [FCWW-1:0]   fcw;
  logic              adpll_en;
  logic              irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  adpll_hop_ctr #(
    .FCWW  (FCWW),
    .NPROF (NPROF),
    .CNT_W (CNT_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .write       (write),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out),
    .ready       (ready),
    .channel_lock(channel_lock),
    .fcw         (fcw),
    .adpll_en    (adpll_en),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the write edge.
  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    sel = 1'b1; write = 1'b1; address = a; data_in = d;
    @(negedge clk);
    sel = 1'b0; write = 1'b0;
  endtask

  task automatic cpu_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
    string       t;
    logic [31:0] e;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    sel = 1'b1; write = 1'b0; address = a;
    @(negedge clk);
    sel = 1'b0;
    check({tag, "_ready"}, {31'b0, ready}, 32'd1);
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check(t, data_out, e);
  endtask

  task automatic wait_en(input string tag);
    int n;
    n = 0;
    while (adpll_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_en"}, {31'b0, adpll_en}, 32'd1);
  endtask

  task automatic count_en(output int n);
    n = 0;
    while (adpll_en === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no_finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; sel = 1'b0; write = 1'b0; address = '0; data_in = '0;
    channel_lock = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fcw",      32'(fcw), 32'h0262_0000);
    check("rst_adpll_en", {31'b0, adpll_en}, 32'd0);
    check("rst_irq",      {31'b0, irq}, 32'd0);
    check("rst_ready",    {31'b0, ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset values through the register port
    cpu_read(6'd2,  32'd1,          "rd_nhop");
    check("ready_drop", {31'b0, ready}, 32'd1);
    @(negedge clk);
    check("ready_idle", {31'b0, ready}, 32'd0);
    cpu_read(6'd3,  32'h100,        "rd_dwell");
    cpu_read(6'd4,  32'hFFFF,       "rd_timeout");
    cpu_read(6'd16, 32'h0262_0000,  "rd_prof0");
    cpu_read(6'd15, 32'hFFFF_FFFF,  "rd_unmapped15");
    cpu_read(6'd0,  32'd0,          "rd_ctrl");
    cpu_read(6'd1,  32'd0,          "rd_status");

    // Two-hop sequence, no loop
    cpu_write(6'd16, 32'h0261_0000);
    cpu_write(6'd17, 32'h0263_0000);
    cpu_write(6'd2,  32'd2);
    cpu_write(6'd3,  32'd4);
    cpu_read(6'd16, 32'h0261_0000, "rd_prof0_w");
    cpu_read(6'd24, 32'hFFFF_FFFF, "rd_unmapped24");
    cpu_write(6'd0, 32'h1);
    check("load_en", {31'b0, adpll_en}, 32'd0);
    wait_en("hop0");
    check("hop0_fcw", 32'(fcw), 32'h0261_0000);
    repeat (2) @(negedge clk);
    channel_lock = 1'b1;
    @(negedge clk);
    count_en(n);
    check("hop0_dwell", 32'(n), 32'd5);
    channel_lock = 1'b0;
    wait_en("hop1");
    check("hop1_fcw", 32'(fcw), 32'h0263_0000);
    repeat (2) @(negedge clk);
    channel_lock = 1'b1;
    @(negedge clk);
    count_en(n);
    check("hop1_dwell", 32'(n), 32'd5);
    channel_lock = 1'b0;
    check("seq_en_off", {31'b0, adpll_en}, 32'd0);
    check("seq_fcw_hold", 32'(fcw), 32'h0263_0000);
    cpu_read(6'd1, 32'h0000_0104, "seq_status");

    // Lock timeout with interrupt
    cpu_write(6'd4, 32'd10);
    cpu_write(6'd0, 32'h9);
    wait_en("to");
    count_en(n);
    check("to_wait_cycles", 32'(n), 32'd11);
    check("to_irq_lag", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("to_irq", {31'b0, irq}, 32'd1);
    cpu_read(6'd1, 32'h0000_0002, "to_status");
    cpu_write(6'd1, 32'h2);
    @(negedge clk);
    check("to_irq_clr", {31'b0, irq}, 32'd0);
    cpu_read(6'd1, 32'h0, "to_status_clr");

    // Lock loss in dwell; timeout counter must restart from zero
    cpu_write(6'd4, 32'd3);
    cpu_write(6'd2, 32'd0);
    cpu_write(6'd0, 32'h9);
    wait_en("ll");
    repeat (2) @(negedge clk);
    channel_lock = 1'b1;
    repeat (2) @(negedge clk);
    channel_lock = 1'b0;
    @(negedge clk);
    check("ll_wait_en", {31'b0, adpll_en}, 32'd1);
    @(negedge clk);
    check("ll_irq", {31'b0, irq}, 32'd1);
    @(negedge clk);
    channel_lock = 1'b1;
    @(negedge clk);
    count_en(n);
    check("ll_dwell", 32'(n), 32'd5);
    cpu_read(6'd1, 32'h0000_000C, "ll_status");

    // Looping run; start|stop together, then stop alone
    cpu_write(6'd4, 32'd100);
    cpu_write(6'd2, 32'd3);
    channel_lock = 1'b1;
    cpu_write(6'd0, 32'h5);
    wait_en("lp");
    check("lp_fcw0", 32'(fcw), 32'h0261_0000);
    repeat (9) @(negedge clk);
    cpu_write(6'd0, 32'h7);
    check("ss_en", {31'b0, adpll_en}, 32'd0);
    check("ss_fcw", 32'(fcw), 32'h0263_0000);
    cpu_read(6'd1, 32'h0000_0100, "ss_status");
    repeat (3) @(negedge clk);
    check("ss_stay_idle", {31'b0, adpll_en}, 32'd0);
    cpu_write(6'd0, 32'h6);
    check("st_idle_en", {31'b0, adpll_en}, 32'd0);
    check("st_idle_fcw", 32'(fcw), 32'h0263_0000);
    cpu_read(6'd1, 32'h0000_0100, "st_idle_status");

    // Restart, busy writes ignored, stop mid-dwell
    cpu_write(6'd0, 32'h5);
    wait_en("rs");
    check("rs_fcw0", 32'(fcw), 32'h0261_0000);
    cpu_write(6'd2,  32'd5);
    cpu_write(6'd3,  32'd9);
    cpu_write(6'd16, 32'h0000_1234);
    cpu_write(6'd0, 32'h6);
    check("stop_en", {31'b0, adpll_en}, 32'd0);
    check("stop_fcw", 32'(fcw), 32'h0261_0000);
    cpu_read(6'd1,  32'h0,          "stop_status");
    cpu_read(6'd2,  32'd3,          "busy_nhop");
    cpu_read(6'd3,  32'd4,          "busy_dwell");
    cpu_read(6'd16, 32'h0261_0000,  "busy_prof0");

    // CTRL readback and soft reset
    cpu_write(6'd0, 32'hC);
    cpu_read(6'd0, 32'hC, "ctrl_rb");
    cpu_write(6'd0, 32'h10);
    cpu_read(6'd0,  32'h0,          "sr_ctrl");
    cpu_read(6'd2,  32'd1,          "sr_nhop");
    cpu_read(6'd3,  32'h100,        "sr_dwell");
    cpu_read(6'd4,  32'hFFFF,       "sr_timeout");
    cpu_read(6'd17, 32'h0262_0000,  "sr_prof1");
    check("sr_fcw", 32'(fcw), 32'h0262_0000);

    // Async reset mid-dwell with a busy NHOP write
    cpu_write(6'd16, 32'h0261_0000);
    cpu_write(6'd2, 32'd3);
    cpu_write(6'd0, 32'h5);
    wait_en("ar");
    cpu_write(6'd2, 32'd7);
    repeat (2) @(negedge clk);
    check("ar_pre_en", {31'b0, adpll_en}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("ar_en",    {31'b0, adpll_en}, 32'd0);
    check("ar_fcw",   32'(fcw), 32'h0262_0000);
    check("ar_irq",   {31'b0, irq}, 32'd0);
    check("ar_ready", {31'b0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    channel_lock = 1'b0;
    cpu_read(6'd2,  32'd1,          "ar_nhop");
    cpu_read(6'd1,  32'h0,          "ar_status");
    cpu_read(6'd16, 32'h0262_0000,  "ar_prof0");
    repeat (3) @(negedge clk);
    check("ar_no_start", {31'b0, adpll_en}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
